// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg
// Shared definitions for the ALU arbiter slice: the ALU control codes the
// MIPS datapath uses, the arbiter FSM state type and the requester port id.
// No ports; imported by rr_arb2 and alu_arbiter.

package alu_arb_pkg;

   // ALU control codes, passed through unchanged to the external ALU
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   // Sequencer states: accept a request, let the ALU settle, hold the result
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Requester identity (port 0 = main execute path, port 1 = auxiliary)
   typedef enum logic {
      PORT0 = 1'b0,
      PORT1 = 1'b1
   } port_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2
// Two-way grant generator for the ALU arbiter. Purely combinational.
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins
// every tie) and removes the 'last' input; otherwise round-robin.
// Ports:
//   valid_0, valid_1  in   request valid of each port
//   last              in   most recently granted port (round-robin build only)
//   grant_0, grant_1  out  one-hot (or zero) grant

module rr_arb2
   import alu_arb_pkg::*;
(
   input  logic  valid_0,
   input  logic  valid_1,
`ifndef ALU_ARB_FIXED_PRIO_EN
   input  port_t last,
`endif
   output logic  grant_0,
   output logic  grant_1
);

   // A lone requester always wins; on a tie the port that was not granted
   // last time wins (or port 0 unconditionally in the fixed-priority build).
   always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant_0 = valid_0;
      grant_1 = valid_1 & ~valid_0;
`else
      grant_0 = valid_0 & (~valid_1 | (last == PORT1));
      grant_1 = valid_1 & (~valid_0 | (last == PORT0));
`endif
   end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares the single combinational 32-bit ALU between two requesters. Takes
// one operation at a time over a valid/ready handshake, drives the ALU from
// registered operand/control lines, captures the result and zero flag and
// holds them on the response channel of the requester that owns the op.
// Build option: ALU_ARB_FIXED_PRIO_EN (fixed priority to port 0, no 'last').
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid_x / req_ready_x       request handshake of port x
//   req_in1_x, req_in2_x, req_ctr_x operands and ALU control of port x
//   rsp_valid_x / rsp_ready_x       response handshake of port x
//   rsp_res, rsp_zero               held result and zero flag (shared)
//   alu_input1, alu_input2, alu_ctr registered drive to the external ALU
//   alu_res, alu_zero               external ALU outputs

module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CTR_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid_0,
   input  logic             req_valid_1,
   output logic             req_ready_0,
   output logic             req_ready_1,
   input  logic [WIDTH-1:0] req_in1_0,
   input  logic [WIDTH-1:0] req_in1_1,
   input  logic [WIDTH-1:0] req_in2_0,
   input  logic [WIDTH-1:0] req_in2_1,
   input  logic [CTR_W-1:0] req_ctr_0,
   input  logic [CTR_W-1:0] req_ctr_1,
   output logic             rsp_valid_0,
   output logic             rsp_valid_1,
   input  logic             rsp_ready_0,
   input  logic             rsp_ready_1,
   output logic [WIDTH-1:0] rsp_res,
   output logic             rsp_zero,
   output logic [WIDTH-1:0] alu_input1,
   output logic [WIDTH-1:0] alu_input2,
   output logic [CTR_W-1:0] alu_ctr,
   input  logic [WIDTH-1:0] alu_res,
   input  logic             alu_zero
);

   state_t state;
   state_t state_nxt;
   port_t  owner;
`ifndef ALU_ARB_FIXED_PRIO_EN
   port_t  last;
`endif
   logic   grant_0;
   logic   grant_1;
   logic   hs_0;
   logic   hs_1;
   logic   rsp_hs;

   rr_arb2 u_arb (
      .valid_0 (req_valid_0),
      .valid_1 (req_valid_1),
`ifndef ALU_ARB_FIXED_PRIO_EN
      .last    (last),
`endif
      .grant_0 (grant_0),
      .grant_1 (grant_1)
   );

   assign hs_0   = req_valid_0 & req_ready_0;
   assign hs_1   = req_valid_1 & req_ready_1;
   assign rsp_hs = (rsp_valid_0 & rsp_ready_0) | (rsp_valid_1 & rsp_ready_1);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: one op in flight; a response handshake returns to IDLE, so
   // a new request can only be taken on the following cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (hs_0 || hs_1) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs: ready only in IDLE for the granted port, response
   // valid only in RESP for the owner (the non-owner's rsp_ready is ignored).
   always_comb begin
      req_ready_0 = 1'b0;
      req_ready_1 = 1'b0;
      rsp_valid_0 = 1'b0;
      rsp_valid_1 = 1'b0;
      if (state == IDLE) begin
         req_ready_0 = grant_0;
         req_ready_1 = grant_1;
      end
      if (state == RESP) begin
         rsp_valid_0 = (owner == PORT0);
         rsp_valid_1 = (owner == PORT1);
      end
   end

   // Datapath: ALU drive registers only load on a request handshake so the
   // ALU inputs stay quiet while idle; the result is captured after the
   // single EXEC cycle and then held until the next op reaches EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner      <= PORT0;
`ifndef ALU_ARB_FIXED_PRIO_EN
         last       <= PORT1;
`endif
         alu_input1 <= '0;
         alu_input2 <= '0;
         alu_ctr    <= '0;
         rsp_res    <= '0;
         rsp_zero   <= 1'b0;
      end else begin
         if (hs_0) begin
            alu_input1 <= req_in1_0;
            alu_input2 <= req_in2_0;
            alu_ctr    <= req_ctr_0;
            owner      <= PORT0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last       <= PORT0;
`endif
         end else if (hs_1) begin
            alu_input1 <= req_in1_1;
            alu_input2 <= req_in2_1;
            alu_ctr    <= req_ctr_1;
            owner      <= PORT1;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last       <= PORT1;
`endif
         end
         if (state == EXEC) begin
            rsp_res  <= alu_res;
            rsp_zero <= alu_zero;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Self-checking bench for alu_arbiter. Provides a behavioural ALU, one
// requester process per port fed from op queues, a negedge monitor logging
// request handshakes, response rises and response handshakes, and test tasks
// that compare those logs against expectations derived from the op lists
// and a simple grant-order model.

module tb_alu_arbiter;
   import alu_arb_pkg::*;

   localparam int WIDTH = 32;
   localparam int CTR_W = 4;
`ifdef ALU_ARB_FIXED_PRIO_EN
   localparam bit FIXED_PRIO = 1'b1;
`else
   localparam bit FIXED_PRIO = 1'b0;
`endif

   typedef struct { logic [31:0] a; logic [31:0] b; logic [3:0] c; } op_t;
   typedef struct { int cyc; int port; logic [31:0] a; logic [31:0] b; logic [3:0] c; } hs_t;
   typedef struct { int cyc; int port; logic [31:0] res; logic zero; } rsp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req_valid_0, req_valid_1;
   logic             req_ready_0, req_ready_1;
   logic [WIDTH-1:0] req_in1_0, req_in1_1, req_in2_0, req_in2_1;
   logic [CTR_W-1:0] req_ctr_0, req_ctr_1;
   logic             rsp_valid_0, rsp_valid_1;
   logic             rsp_ready_0, rsp_ready_1;
   logic [WIDTH-1:0] rsp_res;
   logic             rsp_zero;
   logic [WIDTH-1:0] alu_input1, alu_input2;
   logic [CTR_W-1:0] alu_ctr;
   logic [WIDTH-1:0] alu_res;
   logic             alu_zero;

   op_t  q0[$], q1[$];
   hs_t  hs_log[$];
   rsp_t rv_log[$], rh_log[$];
   int   exp_order[$];
   int   cyc = 0;
   int   hs_cnt_0 = 0, hs_cnt_1 = 0, both_rv = 0;
   int   done_0 = 0, rd_0 = 0, done_1 = 0, rd_1 = 0;
   logic prev_rv0 = 1'b0, prev_rv1 = 1'b0;
   int   checks = 0, errors = 0;

   alu_arbiter #(.WIDTH(WIDTH), .CTR_W(CTR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
      .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
      .req_in1_0(req_in1_0), .req_in1_1(req_in1_1),
      .req_in2_0(req_in2_0), .req_in2_1(req_in2_1),
      .req_ctr_0(req_ctr_0), .req_ctr_1(req_ctr_1),
      .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
      .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
      .rsp_res(rsp_res), .rsp_zero(rsp_zero),
      .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_ctr(alu_ctr),
      .alu_res(alu_res), .alu_zero(alu_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // MIPS ALU behaviour; undefined codes return a ^ b
   function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] c);
      case (c)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return a ^ b;
      endcase
   endfunction

   always_comb begin
      alu_res  = alu_model(alu_input1, alu_input2, alu_ctr);
      alu_zero = (alu_res == 32'd0);
   end

   // Expected grant order when both requesters keep their valids up while
   // they still have work: tie goes to the port not granted last.
   function automatic void build_order(input int n0, input int n1);
      int mlast = 1;
      exp_order.delete();
      while (n0 + n1 > 0) begin
         int g;
         if (n0 > 0 && n1 > 0) g = FIXED_PRIO ? 0 : 1 - mlast;
         else g = (n0 > 0) ? 0 : 1;
         exp_order.push_back(g);
         mlast = g;
         if (g == 0) n0--; else n1--;
      end
   endfunction

   function automatic op_t rand_op();
      op_t o;
      o.a = $urandom;
      o.b = ($urandom_range(0, 3) == 0) ? o.a : $urandom;
      case ($urandom_range(0, 5))
         0: o.c = ALU_AND;
         1: o.c = ALU_OR;
         2: o.c = ALU_ADD;
         3: o.c = ALU_SUB;
         4: o.c = ALU_SLT;
         default: o.c = 4'($urandom_range(0, 15));
      endcase
      return o;
   endfunction

   // Monitor: everything sampled at the falling edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (req_valid_0 && req_ready_0) begin
            hs_log.push_back('{cyc, 0, req_in1_0, req_in2_0, req_ctr_0});
            hs_cnt_0 = hs_cnt_0 + 1;
         end
         if (req_valid_1 && req_ready_1) begin
            hs_log.push_back('{cyc, 1, req_in1_1, req_in2_1, req_ctr_1});
            hs_cnt_1 = hs_cnt_1 + 1;
         end
         if (rsp_valid_0 && !prev_rv0) rv_log.push_back('{cyc, 0, rsp_res, rsp_zero});
         if (rsp_valid_1 && !prev_rv1) rv_log.push_back('{cyc, 1, rsp_res, rsp_zero});
         if (rsp_valid_0 && rsp_ready_0) rh_log.push_back('{cyc, 0, rsp_res, rsp_zero});
         if (rsp_valid_1 && rsp_ready_1) rh_log.push_back('{cyc, 1, rsp_res, rsp_zero});
         if (rsp_valid_0 && rsp_valid_1) both_rv = both_rv + 1;
      end
      prev_rv0 = rsp_valid_0;
      prev_rv1 = rsp_valid_1;
   end

   // Requester port 0: holds valid until handshake, then presents next op
   initial begin
      req_valid_0 = 1'b0; req_in1_0 = '0; req_in2_0 = '0; req_ctr_0 = '0;
      forever begin
         @(posedge clk); #1;
         if (hs_cnt_0 != done_0) begin
            done_0 = hs_cnt_0; rd_0 = rd_0 + 1; req_valid_0 = 1'b0;
         end
         if (!req_valid_0 && q0.size() > rd_0) begin
            req_valid_0 = 1'b1;
            req_in1_0 = q0[rd_0].a; req_in2_0 = q0[rd_0].b; req_ctr_0 = q0[rd_0].c;
         end
      end
   end

   // Requester port 1
   initial begin
      req_valid_1 = 1'b0; req_in1_1 = '0; req_in2_1 = '0; req_ctr_1 = '0;
      forever begin
         @(posedge clk); #1;
         if (hs_cnt_1 != done_1) begin
            done_1 = hs_cnt_1; rd_1 = rd_1 + 1; req_valid_1 = 1'b0;
         end
         if (!req_valid_1 && q1.size() > rd_1) begin
            req_valid_1 = 1'b1;
            req_in1_1 = q1[rd_1].a; req_in2_1 = q1[rd_1].b; req_ctr_1 = q1[rd_1].c;
         end
      end
   end

   task automatic wait_rh(input int n, input int budget, output bit ok);
      int k = 0;
      while (rh_log.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      ok = (rh_log.size() >= n);
   endtask

   task automatic pulse_reset();
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] obs[9];
      string nm[9];
      rst_n = 1'b0; rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
      repeat (2) @(negedge clk);
      obs[0] = 32'(req_ready_0); nm[0] = "rst_req_ready_0";
      obs[1] = 32'(req_ready_1); nm[1] = "rst_req_ready_1";
      obs[2] = 32'(rsp_valid_0); nm[2] = "rst_rsp_valid_0";
      obs[3] = 32'(rsp_valid_1); nm[3] = "rst_rsp_valid_1";
      obs[4] = rsp_res;          nm[4] = "rst_rsp_res";
      obs[5] = 32'(rsp_zero);    nm[5] = "rst_rsp_zero";
      obs[6] = alu_input1;       nm[6] = "rst_alu_input1";
      obs[7] = alu_input2;       nm[7] = "rst_alu_input2";
      obs[8] = 32'(alu_ctr);     nm[8] = "rst_alu_ctr";
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (obs[i] !== 32'd0) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected 0", nm[i], obs[i]);
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_port0_and();
      int hb = hs_log.size(), vb = rv_log.size(), rb = rh_log.size();
      int n1 = 0;
      bit ok;
      @(negedge clk);
      q0.push_back('{32'haaaabbbb, 32'h11112222, ALU_AND});
      wait_rh(rb + 1, 20, ok);
      repeat (3) @(negedge clk);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL p0_timeout: got 0 responses expected 1"); end
      else begin
         checks++;
         if (rv_log[vb].cyc - hs_log[hb].cyc !== 2) begin
            errors++;
            $display("[TB] FAIL p0_latency: got %0d expected 2", rv_log[vb].cyc - hs_log[hb].cyc);
         end
         checks++;
         if (rh_log[rb].res !== 32'h00002222) begin
            errors++; $display("[TB] FAIL p0_res: got %h expected 00002222", rh_log[rb].res);
         end
         checks++;
         if (rh_log[rb].zero !== 1'b0 || rh_log[rb].port != 0) begin
            errors++;
            $display("[TB] FAIL p0_zero_port: got zero %b port %0d expected zero 0 port 0",
                     rh_log[rb].zero, rh_log[rb].port);
         end
      end
      for (int i = vb; i < rv_log.size(); i++) if (rv_log[i].port == 1) n1++;
      checks++;
      if (n1 !== 0) begin errors++; $display("[TB] FAIL p0_rsp_valid_1: got %0d rises expected 0", n1); end
      checks++;
      if (alu_input1 !== 32'haaaabbbb || alu_input2 !== 32'h11112222 || alu_ctr !== ALU_AND) begin
         errors++;
         $display("[TB] FAIL p0_alu_hold: got %h %h %h expected aaaabbbb 11112222 0",
                  alu_input1, alu_input2, alu_ctr);
      end
   endtask

   task automatic test_port1_add_sub();
      int rb = rh_log.size();
      bit ok;
      @(negedge clk);
      q1.push_back('{32'haaaabbbb, 32'h11112222, ALU_ADD});
      q1.push_back('{32'haaaabbbb, 32'haaaabbbb, ALU_SUB});
      wait_rh(rb + 2, 30, ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL p1_timeout: got %0d responses expected 2", rh_log.size() - rb); end
      else begin
         checks++;
         if (rh_log[rb].res !== 32'hbbbbdddd || rh_log[rb].zero !== 1'b0 || rh_log[rb].port != 1) begin
            errors++;
            $display("[TB] FAIL p1_add: got %h z%b p%0d expected bbbbdddd z0 p1",
                     rh_log[rb].res, rh_log[rb].zero, rh_log[rb].port);
         end
         checks++;
         if (rh_log[rb+1].res !== 32'h0 || rh_log[rb+1].zero !== 1'b1 || rh_log[rb+1].port != 1) begin
            errors++;
            $display("[TB] FAIL p1_sub: got %h z%b p%0d expected 00000000 z1 p1",
                     rh_log[rb+1].res, rh_log[rb+1].zero, rh_log[rb+1].port);
         end
      end
   endtask

   task automatic test_round_robin();
      op_t ops0[$], ops1[$];
      int hb, rb, i0 = 0, i1 = 0;
      bit ok;
      pulse_reset();
      hb = hs_log.size(); rb = rh_log.size();
      for (int i = 0; i < 4; i++) begin ops0.push_back(rand_op()); ops1.push_back(rand_op()); end
      build_order(4, 4);
      @(negedge clk);
      foreach (ops0[i]) begin q0.push_back(ops0[i]); q1.push_back(ops1[i]); end
      wait_rh(rb + 8, 100, ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL rr_timeout: got %0d responses expected 8", rh_log.size() - rb); end
      else begin
         for (int i = 0; i < 8; i++) begin
            op_t o;
            logic [31:0] er;
            if (exp_order[i] == 0) begin o = ops0[i0]; i0++; end else begin o = ops1[i1]; i1++; end
            er = alu_model(o.a, o.b, o.c);
            checks++;
            if (rh_log[rb+i].port != exp_order[i]) begin
               errors++; $display("[TB] FAIL rr_grant[%0d]: got %0d expected %0d", i, rh_log[rb+i].port, exp_order[i]);
            end
            checks++;
            if (rh_log[rb+i].res !== er || rh_log[rb+i].zero !== (er == 32'd0)) begin
               errors++; $display("[TB] FAIL rr_res[%0d]: got %h expected %h", i, rh_log[rb+i].res, er);
            end
            if (i > 0) begin
               checks++;
               if (hs_log[hb+i].cyc - hs_log[hb+i-1].cyc !== 3) begin
                  errors++;
                  $display("[TB] FAIL rr_spacing[%0d]: got %0d expected 3", i, hs_log[hb+i].cyc - hs_log[hb+i-1].cyc);
               end
            end
         end
      end
   endtask

   task automatic test_stall();
      int hb = hs_log.size(), rb = rh_log.size(), k;
      bit ok;
      @(negedge clk);
      rsp_ready_0 = 1'b0;
      q0.push_back('{32'haaaabbbb, 32'h11112222, ALU_OR});
      k = 0;
      while (!(req_valid_0 && req_ready_0) && k < 20) begin @(negedge clk); k++; end
      checks++;
      if (k >= 20) begin errors++; $display("[TB] FAIL stall_req_hs: got none expected handshake"); end
      @(negedge clk);
      q1.push_back('{32'd1, 32'd2, ALU_ADD});
      k = 0;
      while (!rsp_valid_0 && k < 20) begin @(negedge clk); k++; end
      for (int s = 0; s < 5; s++) begin
         if (s > 0) @(negedge clk);
         checks++;
         if (rsp_valid_0 !== 1'b1 || rsp_res !== 32'hbbbbbbbb || rsp_zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_hold[%0d]: got v%b %h z%b expected v1 bbbbbbbb z0", s, rsp_valid_0, rsp_res, rsp_zero);
         end
         checks++;
         if (req_ready_1 !== 1'b0 || rsp_valid_1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_port1[%0d]: got ready %b rsp_valid %b expected 0 0", s, req_ready_1, rsp_valid_1);
         end
      end
      @(posedge clk); #1;
      rsp_ready_0 = 1'b1;
      wait_rh(rb + 2, 40, ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL stall_timeout: got %0d responses expected 2", rh_log.size() - rb); end
      else begin
         checks++;
         if (rh_log[rb].port != 0 || rh_log[rb].res !== 32'hbbbbbbbb) begin
            errors++; $display("[TB] FAIL stall_rsp: got p%0d %h expected p0 bbbbbbbb", rh_log[rb].port, rh_log[rb].res);
         end
         checks++;
         if (hs_log[hb+1].port != 1 || hs_log[hb+1].cyc - rh_log[rb].cyc !== 1) begin
            errors++;
            $display("[TB] FAIL stall_next_grant: got p%0d after %0d expected p1 after 1",
                     hs_log[hb+1].port, hs_log[hb+1].cyc - rh_log[rb].cyc);
         end
         checks++;
         if (rh_log[rb+1].port != 1 || rh_log[rb+1].res !== 32'd3) begin
            errors++; $display("[TB] FAIL stall_p1_res: got p%0d %h expected p1 3", rh_log[rb+1].port, rh_log[rb+1].res);
         end
      end
   endtask

   task automatic test_reset_mid_exec();
      int vb = rv_log.size(), rb, k = 0;
      bit ok;
      @(negedge clk);
      q0.push_back('{32'd5, 32'd7, ALU_ADD});
      while (!(req_valid_0 && req_ready_0) && k < 20) begin @(negedge clk); k++; end
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (alu_input1 !== 32'd0 || alu_input2 !== 32'd0 || alu_ctr !== 4'd0) begin
         errors++; $display("[TB] FAIL rexec_alu: got %h %h %h expected 0 0 0", alu_input1, alu_input2, alu_ctr);
      end
      checks++;
      if (rsp_valid_0 !== 1'b0 || rsp_valid_1 !== 1'b0 || rsp_res !== 32'd0 || rsp_zero !== 1'b0 ||
          req_ready_0 !== 1'b0 || req_ready_1 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rexec_outputs: got v%b%b %h z%b r%b%b expected all 0",
                  rsp_valid_0, rsp_valid_1, rsp_res, rsp_zero, req_ready_0, req_ready_1);
      end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      checks++;
      if (rv_log.size() - vb !== 0) begin
         errors++; $display("[TB] FAIL rexec_no_rsp: got %0d responses expected 0", rv_log.size() - vb);
      end
      rb = rh_log.size();
      q0.push_back('{32'd9, 32'd9, ALU_SUB});
      wait_rh(rb + 1, 20, ok);
      checks++;
      if (!ok || rh_log[rb].res !== 32'd0 || rh_log[rb].zero !== 1'b1) begin
         errors++; $display("[TB] FAIL rexec_after: got ok%b %h z%b expected ok1 0 z1", ok, rh_log[rb].res, rh_log[rb].zero);
      end
   endtask

   task automatic test_back_to_back();
      op_t ops[$];
      int hb = hs_log.size(), vb = rv_log.size(), rb = rh_log.size();
      bit ok;
      for (int i = 0; i < 4; i++) ops.push_back(rand_op());
      @(negedge clk);
      foreach (ops[i]) q0.push_back(ops[i]);
      wait_rh(rb + 4, 60, ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL b2b_timeout: got %0d responses expected 4", rh_log.size() - rb); end
      else begin
         checks++;
         if (rv_log[vb].cyc - hs_log[hb].cyc !== 2) begin
            errors++; $display("[TB] FAIL b2b_latency: got %0d expected 2", rv_log[vb].cyc - hs_log[hb].cyc);
         end
         for (int i = 0; i < 4; i++) begin
            logic [31:0] er = alu_model(ops[i].a, ops[i].b, ops[i].c);
            checks++;
            if (rh_log[rb+i].res !== er || rh_log[rb+i].port != 0) begin
               errors++; $display("[TB] FAIL b2b_res[%0d]: got p%0d %h expected p0 %h", i, rh_log[rb+i].port, rh_log[rb+i].res, er);
            end
            if (i > 0) begin
               checks++;
               if (hs_log[hb+i].cyc - hs_log[hb+i-1].cyc !== 3) begin
                  errors++;
                  $display("[TB] FAIL b2b_spacing[%0d]: got %0d expected 3", i, hs_log[hb+i].cyc - hs_log[hb+i-1].cyc);
               end
            end
         end
      end
   endtask

   task automatic test_random();
      op_t ops0[$], ops1[$];
      int hb, vb, rb, bb, i0 = 0, i1 = 0, k = 0, n;
      pulse_reset();
      hb = hs_log.size(); vb = rv_log.size(); rb = rh_log.size(); bb = both_rv;
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 1) == 0) ops0.push_back(rand_op()); else ops1.push_back(rand_op());
      end
      n = ops0.size() + ops1.size();
      build_order(ops0.size(), ops1.size());
      @(negedge clk);
      foreach (ops0[i]) q0.push_back(ops0[i]);
      foreach (ops1[i]) q1.push_back(ops1[i]);
      while (rh_log.size() < rb + n && k < 2000) begin
         @(posedge clk); #1;
         rsp_ready_0 = ($urandom_range(0, 3) != 0);
         rsp_ready_1 = ($urandom_range(0, 3) != 0);
         k++;
      end
      rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
      checks++;
      if (rh_log.size() < rb + n) begin
         errors++; $display("[TB] FAIL rnd_timeout: got %0d responses expected %0d", rh_log.size() - rb, n);
      end
      else begin
         for (int i = 0; i < n; i++) begin
            op_t o;
            logic [31:0] er;
            if (exp_order[i] == 0) begin o = ops0[i0]; i0++; end else begin o = ops1[i1]; i1++; end
            er = alu_model(o.a, o.b, o.c);
            checks++;
            if (hs_log[hb+i].port != exp_order[i] || rh_log[rb+i].port != exp_order[i]) begin
               errors++;
               $display("[TB] FAIL rnd_grant[%0d]: got hs p%0d rsp p%0d expected p%0d",
                        i, hs_log[hb+i].port, rh_log[rb+i].port, exp_order[i]);
            end
            checks++;
            if (rh_log[rb+i].res !== er || rh_log[rb+i].zero !== (er == 32'd0)) begin
               errors++;
               $display("[TB] FAIL rnd_res[%0d]: got %h z%b expected %h z%b", i, rh_log[rb+i].res,
                        rh_log[rb+i].zero, er, (er == 32'd0));
            end
            checks++;
            if (rv_log[vb+i].cyc - hs_log[hb+i].cyc !== 2) begin
               errors++; $display("[TB] FAIL rnd_latency[%0d]: got %0d expected 2", i, rv_log[vb+i].cyc - hs_log[hb+i].cyc);
            end
         end
      end
      checks++;
      if (both_rv - bb !== 0) begin
         errors++; $display("[TB] FAIL rnd_both_rsp_valid: got %0d cycles expected 0", both_rv - bb);
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_port0_and();
      test_port1_add_sub();
      test_round_robin();
      test_stall();
      test_reset_mid_exec();
      test_back_to_back();
      test_random();
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer that shares the single 32-bit ALU of the MIPS datapath between the main execute path (port 0) and an auxiliary requester (port 1, e.g. branch-compare or debug unit). It accepts operations over valid/ready handshakes, grants round-robin, and drives the ALU from registered operand/control lines. It captures the ALU result and zero flag and returns them to the granted requester on a held response channel. The ALU itself stays combinational and external.

## Interface
- Parameters
- WIDTH, 32, operand/result width
- CTR_W, 4, ALU control width
- Ports
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_0 / req_valid_1  in  1  operation request per port
- req_ready_0 / req_ready_1  out  1  request accepted when valid&ready
- req_in1_0 / req_in1_1  in  WIDTH  first operand
- req_in2_0 / req_in2_1  in  WIDTH  second operand
- req_ctr_0 / req_ctr_1  in  CTR_W  ALU control code
- rsp_valid_0 / rsp_valid_1  out  1  result available for that port
- rsp_ready_0 / rsp_ready_1  in  1  requester consumes result
- rsp_res  out  WIDTH  registered ALU result (shared by both ports)
- rsp_zero  out  1  registered ALU zero flag
- alu_input1 / alu_input2  out  WIDTH  registered ALU operands
- alu_ctr  out  CTR_W  registered ALU control
- alu_res  in  WIDTH  ALU result
- alu_zero  in  1  ALU zero flag

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: grant one valid port; req_ready_g=1 for granted port only, 0 for the other. On handshake latch in1/in2/ctr into alu_input1/alu_input2/alu_ctr, record owner, go EXEC.
- EXEC: one cycle; capture alu_res/alu_zero into rsp_res/rsp_zero, go RESP.
- RESP: rsp_valid_owner=1, other rsp_valid=0; rsp_res/rsp_zero stable until rsp_ready_owner=1, then go IDLE.
- Round-robin: pointer `last` holds the most recently granted port. Both valid: grant the port != last. One valid: grant it. `last` updates only on request handshake.
- Control codes passed unchanged (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT); undefined codes are not filtered, and the result is whatever the ALU returns.
- alu_* outputs hold their last values outside EXEC (no toggling while idle).
- req_ready may depend combinationally on req_valid of both ports. Requesters must not drop valid before handshake.
- Reset mid-operation: in-flight op discarded, no response issued, FSM to IDLE.

## Timing
- Reset values: FSM=IDLE, last=1 (port 0 wins first tie), req_ready_0/1=0 until valid seen, rsp_valid_0/1=0, rsp_res=0, rsp_zero=0, alu_input1/2=0, alu_ctr=0.
- Request handshake in cycle N: alu_* valid from N+1; result registered at end of N+1; rsp_valid high in N+2.
- Minimum per-op occupancy 3 cycles (IDLE, EXEC, RESP with immediate rsp_ready). A new request is never accepted in the same cycle as a response handshake.
- rsp_ready held low: arbiter stalls in RESP indefinitely; both req_ready stay 0.
- rsp_ready asserted on the non-owner port: ignored.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: fixed priority, port 0 always wins when both valid, and the `last` pointer is removed. Port 1 may starve.
- Undefined: round-robin as above.

## Structure
- Package alu_arb_pkg: ALU control code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT), FSM state typedef, port-id typedef.
- One natural sub-module: rr_arb2, a 2-way grant generator (valids, last -> grant), with the fixed-priority variant selected by the macro inside it.

## Test plan
- Port 0 only: in1=aaaabbbb, in2=11112222, ctr=0000, rsp_ready=1 -> rsp_valid_0 at N+2, rsp_res=00002222, rsp_zero=0, rsp_valid_1 never high.
- Port 1 ADD, same operands -> rsp_valid_1, rsp_res=bbbbdddd. Then SUB with in1=in2=aaaabbbb -> rsp_res=00000000, rsp_zero=1.
- Both ports valid continuously, 4 ops each, rsp_ready=1 -> grants alternate 0,1,0,1,…, starting with port 0. With ALU_ARB_FIXED_PRIO_EN, all port-0 ops complete before any port-1 op.
- OR op, rsp_ready_0 held low 5 cycles -> rsp_valid_0 and rsp_res=bbbbbbbb stable for all 5 cycles, req_ready_1=0 throughout, then IDLE one cycle after rsp_ready_0.
- rst_n pulsed low during EXEC -> all outputs return to reset values asynchronously, no rsp_valid afterwards, and the next request is served normally.
- Back-to-back requests on port 0 -> handshakes spaced exactly 3 cycles apart with immediate rsp_ready.
